// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DISP_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // The prescaler advances only while the stopwatch is timing.
  function automatic logic is_counting(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Command inputs and display/status outputs of the stopwatch controller.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic              start_stop;
  logic              lap;
  logic              zero;
  logic [DISP_W-1:0] disp;
  logic              running;
  logic              lap_active;
  logic              tick;
  logic              overflow;

  modport master (
    output start_stop, lap, zero,
    input  disp, running, lap_active, tick, overflow
  );

  modport slave (
    input  start_stop, lap, zero,
    output disp, running, lap_active, tick, overflow
  );

endinterface

// File: rtl/bcd_digit.sv
// One decade of the count cascade: increments on inc, wraps 9 to 0 and
// raises carry combinationally on the increment that wraps.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               clear,
  input  logic               clr_sync,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  assign carry = inc & (q == BCD_MAX);

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (clr_sync) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap stopwatch: input synchronisers, command FSM, prescaler,
// four cascaded BCD digits and the live/lap display select.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic        CLOCK_50,
  input  logic        clear,
  stopwatch_if.slave  bus
);
  import stopwatch_pkg::*;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [2:0] ss_sync;
  logic [2:0] lap_sync;
  logic [2:0] zero_sync;
  logic       ss_edge;
  logic       lap_edge;
  logic       zero_edge;

  state_t state;
  state_t state_next;
  logic   lap_load;
  logic   zero_clr;
  logic   count_en;

  logic [PRE_W-1:0]        pre;
  logic                    wrap;
  logic [NUM_DIGITS:0]     inc_chain;
  logic [DISP_W-1:0]       count;
  logic [DISP_W-1:0]       lap_reg;
  logic                    tick_q;
  logic                    overflow_q;

  // [0],[1] form the synchroniser, [2] is the delay flop for edge detection.
  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      ss_sync   <= '0;
      lap_sync  <= '0;
      zero_sync <= '0;
    end else begin
      ss_sync   <= {ss_sync[1:0],   bus.start_stop};
      lap_sync  <= {lap_sync[1:0],  bus.lap};
      zero_sync <= {zero_sync[1:0], bus.zero};
    end
  end

  assign ss_edge   = ss_sync[1]   & ~ss_sync[2];
  assign lap_edge  = lap_sync[1]  & ~lap_sync[2];
  assign zero_edge = zero_sync[1] & ~zero_sync[2];

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start_stop outranks lap; a losing edge is simply discarded.
  always_comb begin
    state_next = state;
    lap_load   = 1'b0;
    zero_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_edge) state_next = RUN;
      end
      RUN: begin
        if (ss_edge) begin
          state_next = PAUSE;
        end else if (lap_edge) begin
          state_next = LAP;
          lap_load   = 1'b1;
        end
      end
      LAP: begin
        if (ss_edge) begin
          state_next = PAUSE;
        end else if (lap_edge) begin
          state_next = RUN;
        end
      end
      PAUSE: begin
        if (ss_edge) begin
          state_next = RUN;
        end else if (zero_edge) begin
          state_next = IDLE;
          zero_clr   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Enable comes from the current state, so a stop landing on a wrap edge
  // still completes that increment before the prescaler freezes at 0.
  assign count_en = is_counting(state);
  assign wrap     = count_en && (pre == PRE_LAST);

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      pre <= '0;
    end else if (zero_clr) begin
      pre <= '0;
    end else if (count_en) begin
      pre <= wrap ? '0 : pre + PRE_W'(1);
    end
  end

  assign inc_chain[0] = wrap;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .CLOCK_50 (CLOCK_50),
      .clear    (clear),
      .clr_sync (zero_clr),
      .inc      (inc_chain[g]),
      .q        (count[g*DIGIT_W +: DIGIT_W]),
      .carry    (inc_chain[g+1])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tick_q     <= wrap;
      overflow_q <= inc_chain[NUM_DIGITS];
    end
  end

  // Captures the registered (pre-increment) count on the RUN->LAP edge.
  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      lap_reg <= '0;
    end else if (zero_clr) begin
      lap_reg <= '0;
    end else if (lap_load) begin
      lap_reg <= count;
    end
  end

  assign bus.disp       = (state == LAP) ? lap_reg : count;
  assign bus.running    = is_counting(state);
  assign bus.lap_active = (state == LAP);
  assign bus.tick       = tick_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4: stimulus queues the
// expected display/overflow/spacing of each tick, a monitor checks on tick.
module tb_stopwatch_ctrl;

  logic CLOCK_50 = 1'b0;
  logic clear    = 1'b0;

  stopwatch_if sw ();

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .PRE_W    (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .clear    (clear),
    .bus      (sw)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] disp;
    logic        ovf;
    int unsigned gap;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic o, input int unsigned g);
    exp_t e;
    e.disp = d;
    e.ovf  = o;
    e.gap  = g;
    sb.push_back(e);
  endtask

  // Monitor: every tick pops one expectation; gap is cycles since last tick.
  initial begin : monitor
    int unsigned cyc       = 0;
    int unsigned last_tick = 0;
    logic        prev_tick = 1'b0;
    exp_t        e;
    forever begin
      @(negedge CLOCK_50);
      cyc++;
      if (prev_tick && !sw.tick) chk("overflow_width", 32'(sw.overflow), 32'd0);
      if (sw.tick) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: got tick with disp %h, expected no tick at %0t", sw.disp, $time);
        end else begin
          e = sb.pop_front();
          chk("tick_disp", 32'(sw.disp), 32'(e.disp));
          chk("tick_overflow", 32'(sw.overflow), 32'(e.ovf));
          if (e.gap != 0) chk("tick_gap", cyc - last_tick, e.gap);
        end
        last_tick = cyc;
      end
      prev_tick = sw.tick;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.zero       = 1'b0;

    step(3);
    @(negedge CLOCK_50);
    chk("reset_disp", 32'(sw.disp), 32'h0);
    chk("reset_running", 32'(sw.running), 32'd0);
    chk("reset_lap_active", 32'(sw.lap_active), 32'd0);
    chk("reset_tick", 32'(sw.tick), 32'd0);
    chk("reset_overflow", 32'(sw.overflow), 32'd0);
    clear = 1'b1;
    step(2);

    // Expected ticks for the first run (S = RUN entry, R = S+71).
    for (int unsigned n = 1; n <= 12; n++)
      push(to_bcd(n), 1'b0, (n == 1) ? 0 : ((n == 12) ? 27 : 4));
    push(16'h0013, 1'b0, 4);
    push(16'h0013, 1'b0, 4);
    push(16'h0013, 1'b0, 4);
    push(16'h0013, 1'b0, 4);
    push(16'h0017, 1'b0, 4);
    push(16'h0017, 1'b0, 4);
    push(16'h0019, 1'b0, 4);
    push(16'h0020, 1'b0, 4);

    // Start: sampled at edge k, RUN at k+2.
    sw.start_stop = 1'b1;
    step(1);
    sw.start_stop = 1'b0;
    step(1);
    @(negedge CLOCK_50);
    chk("start_latency_k1", 32'(sw.running), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    chk("start_running", 32'(sw.running), 32'd1);
    chk("start_disp", 32'(sw.disp), 32'h0);
    step(40);
    @(negedge CLOCK_50);
    chk("carry_0010", 32'(sw.disp), 32'h0010);

    // Stop so that PAUSE is entered with prescaler=2.
    step(3);
    sw.start_stop = 1'b1;
    step(1);
    sw.start_stop = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("pause_running", 32'(sw.running), 32'd0);
    chk("pause_disp", 32'(sw.disp), 32'h0011);
    for (int unsigned i = 0; i < 4; i++) begin
      step(5);
      @(negedge CLOCK_50);
      chk("pause_hold", 32'(sw.disp), 32'h0011);
    end

    // Resume: next tick two cycles after RUN entry (gap 27 from tick 11).
    sw.start_stop = 1'b1;
    step(1);
    sw.start_stop = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("resume_running", 32'(sw.running), 32'd1);
    step(2);

    // Lap at 0013, frozen while ticks continue, released at 0016.
    step(3);
    sw.lap = 1'b1;
    step(1);
    sw.lap = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("lap_active_on", 32'(sw.lap_active), 32'd1);
    chk("lap_disp", 32'(sw.disp), 32'h0013);
    step(9);
    sw.lap = 1'b1;
    step(1);
    sw.lap = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("lap_release_active", 32'(sw.lap_active), 32'd0);
    chk("lap_release_running", 32'(sw.running), 32'd1);
    chk("lap_release_disp", 32'(sw.disp), 32'h0016);

    // RUN->LAP on the tick edge captures the pre-increment count.
    step(3);
    sw.lap = 1'b1;
    step(1);
    sw.lap = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("lap_on_tick_active", 32'(sw.lap_active), 32'd1);
    chk("lap_on_tick_disp", 32'(sw.disp), 32'h0017);
    sw.lap = 1'b1;
    step(1);
    sw.lap = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("back_to_run_active", 32'(sw.lap_active), 32'd0);
    chk("back_to_run_disp", 32'(sw.disp), 32'h0018);

    // zero in RUN ignored; start_stop+lap together on a wrap edge -> PAUSE.
    sw.zero = 1'b1;
    step(1);
    sw.zero = 1'b0;
    step(1);
    sw.start_stop = 1'b1;
    sw.lap        = 1'b1;
    step(1);
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    @(negedge CLOCK_50);
    chk("zero_in_run_ignored", 32'(sw.running), 32'd1);
    step(2);
    @(negedge CLOCK_50);
    chk("priority_running", 32'(sw.running), 32'd0);
    chk("priority_lap_active", 32'(sw.lap_active), 32'd0);
    chk("stop_on_wrap_disp", 32'(sw.disp), 32'h0020);
    step(6);
    @(negedge CLOCK_50);
    chk("lap_not_queued_running", 32'(sw.running), 32'd0);
    chk("lap_not_queued_active", 32'(sw.lap_active), 32'd0);

    // zero in PAUSE returns to IDLE with everything cleared.
    sw.zero = 1'b1;
    step(1);
    sw.zero = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("zero_disp", 32'(sw.disp), 32'h0);
    chk("zero_running", 32'(sw.running), 32'd0);

    // Long run through 9999 -> 0000 up to 0037.
    for (int unsigned n = 1; n <= 10037; n++)
      push(to_bcd(n % 10000), (n % 10000) == 0, (n == 1) ? 0 : 4);
    sw.start_stop = 1'b1;
    step(1);
    sw.start_stop = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("rerun_running", 32'(sw.running), 32'd1);
    step(3);
    @(negedge CLOCK_50);
    chk("first_tick_not_early", 32'(sw.tick), 32'd0);
    step(1);
    @(negedge CLOCK_50);
    chk("first_tick_at_div", 32'(sw.tick), 32'd1);
    step(40144);
    step(2);
    @(negedge CLOCK_50);
    chk("pre_reset_disp", 32'(sw.disp), 32'h0037);

    // Asynchronous clear mid-count.
    clear = 1'b0;
    #1;
    chk("clear_disp", 32'(sw.disp), 32'h0);
    chk("clear_running", 32'(sw.running), 32'd0);
    chk("clear_lap_active", 32'(sw.lap_active), 32'd0);
    chk("clear_tick", 32'(sw.tick), 32'd0);
    chk("clear_overflow", 32'(sw.overflow), 32'd0);
    step(2);
    clear = 1'b1;
    step(1);
    sw.start_stop = 1'b1;
    step(1);
    sw.start_stop = 1'b0;
    step(2);
    @(negedge CLOCK_50);
    chk("cmd_after_clear_running", 32'(sw.running), 32'd1);
    chk("cmd_after_clear_disp", 32'(sw.disp), 32'h0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
